// File: rtl/opti_coeff_fetch.sv
// opti_coeff_fetch: sequencer for the opti_coeffs Q2.14 coefficient ROM.
// Walks the ROM one biquad section at a time, gathers [b0 b1 b2 a1 a2] and
// presents each section to the biquad datapath over a valid/ready handshake.
// Pulses done after the last section is accepted.
//
// Build option: define OPTI_COEFF_PREFETCH_EN to add a shadow bank. The next
// section is then fetched while the current one is presented, so bundles can
// go out back-to-back. Without it a single bank is used, and the next section
// is refetched after each handshake.
//
// Handshake: a bundle transfers on a rising edge where sec_valid && sec_ready.
// While sec_valid is high, sec_idx and sec_b0..sec_a2 hold steady until that
// transfer. sec_valid never drops without a transfer, except on abort or reset.
// sec_ready is ignored while sec_valid is low.
module opti_coeff_fetch #(
  parameter int NSEC      = 5,
  parameter int CW        = 16,
  parameter int AW        = 5,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rom_addr,
  input  logic [CW-1:0] rom_coeff,
  output logic [2:0]    sec_idx,
  output logic [CW-1:0] sec_b0,
  output logic [CW-1:0] sec_b1,
  output logic [CW-1:0] sec_b2,
  output logic [CW-1:0] sec_a1,
  output logic [CW-1:0] sec_a2,
  output logic          sec_valid,
  input  logic          sec_ready,
  output logic          busy,
  output logic          done
);

  // IDLE: waiting for start. FETCH: busy with no bundle presented.
  // PRESENT: bundle valid on the outputs.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  localparam logic [AW-1:0] BASE      = AW'(BASE_ADDR);
  localparam logic [2:0]    LAST_SEC  = 3'(NSEC - 1);
  localparam logic [2:0]    LAST_SLOT = 3'd4;

  logic [1:0]    state_q, state_d;
  logic [2:0]    k_q, k_d;               // word slot within the section being fetched
  logic [2:0]    sec_idx_q, sec_idx_d;   // section index of the presented bundle
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          done_q, done_d;
  logic [CW-1:0] coef_q [5];             // presented bank, order b0 b1 b2 a1 a2
  logic [CW-1:0] coef_d [5];

  logic hs;
  logic last_sec;

`ifdef OPTI_COEFF_PREFETCH_EN
  logic [CW-1:0] sh_q [5];               // shadow bank filled while presenting
  logic [CW-1:0] sh_d [5];
  logic          sh_full_q, sh_full_d;
  logic          fetch_act_q, fetch_act_d; // more sections remain to be fetched
  logic [2:0]    fsec_q, fsec_d;           // section currently being fetched
  logic          fetch_en;
  logic          fetch_last;
  logic          front_free;
`endif

  assign hs       = (state_q == ST_PRESENT) && sec_ready;
  assign last_sec = (sec_idx_q == LAST_SEC);

`ifdef OPTI_COEFF_PREFETCH_EN
  // A full shadow stalls the fetcher until the presented bundle is taken.
  assign fetch_en   = fetch_act_q && (!sh_full_q || hs);
  assign fetch_last = fetch_en && (k_q == LAST_SLOT);
  // The presented bank can take new data this edge.
  assign front_free = (state_q == ST_FETCH) || hs;
`endif

  // Next-state logic for sequencing, fetch and presentation.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    sec_idx_d  = sec_idx_q;
    rom_addr_d = rom_addr_q;
    done_d     = 1'b0;
    coef_d     = coef_q;
`ifdef OPTI_COEFF_PREFETCH_EN
    sh_d        = sh_q;
    sh_full_d   = sh_full_q;
    fetch_act_d = fetch_act_q;
    fsec_d      = fsec_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FETCH;
          k_d         = 3'd0;
          fsec_d      = 3'd0;
          fetch_act_d = 1'b1;
          sh_full_d   = 1'b0;
          rom_addr_d  = BASE;
          sec_idx_d   = 3'd0;
        end
      end
      ST_FETCH, ST_PRESENT: begin
        if (fetch_en) begin
          sh_d[k_q]  = rom_coeff;
          rom_addr_d = rom_addr_q + AW'(1);
          k_d        = k_q + 3'd1;
          if (k_q == LAST_SLOT) begin
            k_d         = 3'd0;
            fsec_d      = fsec_q + 3'd1;
            fetch_act_d = (fsec_q != LAST_SEC);
          end
        end
        if (fetch_last && front_free) begin
          // Completed section goes straight to the outputs, last word from the ROM.
          coef_d[0] = sh_q[0];
          coef_d[1] = sh_q[1];
          coef_d[2] = sh_q[2];
          coef_d[3] = sh_q[3];
          coef_d[4] = rom_coeff;
          state_d   = ST_PRESENT;
          sec_idx_d = fsec_q;
        end else if (hs && sh_full_q) begin
          coef_d    = sh_q;
          sh_full_d = 1'b0;
          sec_idx_d = sec_idx_q + 3'd1;
        end else if (hs) begin
          if (last_sec) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            rom_addr_d = BASE;
            sec_idx_d  = 3'd0;
          end else begin
            state_d = ST_FETCH;
          end
        end
        if (fetch_last && !front_free) begin
          sh_full_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_FETCH;
          k_d        = 3'd0;
          rom_addr_d = BASE;
          sec_idx_d  = 3'd0;
        end
      end
      ST_FETCH: begin
        coef_d[k_q] = rom_coeff;
        rom_addr_d  = rom_addr_q + AW'(1);
        k_d         = k_q + 3'd1;
        if (k_q == LAST_SLOT) begin
          k_d     = 3'd0;
          state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (sec_ready) begin
          if (last_sec) begin
            state_d    = ST_IDLE;
            done_d     = 1'b1;
            rom_addr_d = BASE;
            sec_idx_d  = 3'd0;
          end else begin
            state_d   = ST_FETCH;
            sec_idx_d = sec_idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
`endif

    // Abort wins over everything, including a same-cycle start.
    // Coefficient registers keep whatever they hold.
    if (abort) begin
      state_d    = ST_IDLE;
      k_d        = 3'd0;
      sec_idx_d  = 3'd0;
      rom_addr_d = BASE;
      done_d     = 1'b0;
      coef_d     = coef_q;
`ifdef OPTI_COEFF_PREFETCH_EN
      sh_full_d   = 1'b0;
      fetch_act_d = 1'b0;
      fsec_d      = 3'd0;
`endif
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      k_q        <= 3'd0;
      sec_idx_q  <= 3'd0;
      rom_addr_q <= BASE;
      done_q     <= 1'b0;
      for (int i = 0; i < 5; i++) coef_q[i] <= '0;
`ifdef OPTI_COEFF_PREFETCH_EN
      for (int i = 0; i < 5; i++) sh_q[i] <= '0;
      sh_full_q   <= 1'b0;
      fetch_act_q <= 1'b0;
      fsec_q      <= 3'd0;
`endif
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      sec_idx_q  <= sec_idx_d;
      rom_addr_q <= rom_addr_d;
      done_q     <= done_d;
      coef_q     <= coef_d;
`ifdef OPTI_COEFF_PREFETCH_EN
      sh_q        <= sh_d;
      sh_full_q   <= sh_full_d;
      fetch_act_q <= fetch_act_d;
      fsec_q      <= fsec_d;
`endif
    end
  end

  assign rom_addr  = rom_addr_q;
  assign sec_idx   = sec_idx_q;
  assign sec_b0    = coef_q[0];
  assign sec_b1    = coef_q[1];
  assign sec_b2    = coef_q[2];
  assign sec_a1    = coef_q[3];
  assign sec_a2    = coef_q[4];
  assign sec_valid = (state_q == ST_PRESENT);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_opti_coeff_fetch.sv
// Testbench for opti_coeff_fetch (default build, or with OPTI_COEFF_PREFETCH_EN).
// The reference model predicts, per section, the edge at which its bundle
// appears, from the fetch/handshake timing rules. Bundle contents come from a
// queue of expected ROM words.
module tb_opti_coeff_fetch;
  localparam int NSEC = 5;
  localparam int CW   = 16;
  localparam int AW   = 5;
  localparam int BASE = 0;
`ifdef OPTI_COEFF_PREFETCH_EN
  localparam int EXP_RUN = 26;  // start edge to last handshake edge, ready held high
`else
  localparam int EXP_RUN = 30;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sec_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_coeff;
  logic [2:0]    sec_idx;
  logic [CW-1:0] sec_b0, sec_b1, sec_b2, sec_a1, sec_a2;
  logic          sec_valid, busy, done;

  logic [CW-1:0] rom [32];
  logic [CW-1:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;

  opti_coeff_fetch #(.NSEC(NSEC), .CW(CW), .AW(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rom_addr(rom_addr), .rom_coeff(rom_coeff), .sec_idx(sec_idx),
    .sec_b0(sec_b0), .sec_b1(sec_b1), .sec_b2(sec_b2), .sec_a1(sec_a1), .sec_a2(sec_a2),
    .sec_valid(sec_valid), .sec_ready(sec_ready), .busy(busy), .done(done)
  );

  // Clock, edge counter and combinational ROM.
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  assign rom_coeff = rom[rom_addr];

  // Run one job. mode: 0 ready high, 1 random ready, 2 stall 20 cycles on
  // section 2, 3 ready low for 10 cycles after start.
  // stop_kind: 0 complete, 1 abort during fetch of section 3,
  // 2 reset while section 1 is presented.
  task automatic run_stream(input int mode, input int stop_kind);
    int e0, cur, now, stall, hs_obs, done_obs, last_obs, c;
    int hs_e [NSEC];
    int f_e  [NSEC];
    int p_e  [NSEC];
    logic exp_v, exp_busy, exp_done, rdy, finished;
    logic [5*CW-1:0] exp_bundle;
    logic [CW-1:0] dummy;
    exp_q.delete();
    for (int s = 0; s < NSEC; s++)
      for (int j = 0; j < 5; j++) exp_q.push_back(rom[BASE + 5*s + j]);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b0;
    sec_ready = ($urandom_range(0, 1) == 1);
    e0 = edge_cnt + 1;
    f_e[0] = e0 + 5;
    p_e[0] = e0 + 5;
    cur = 0; stall = 0; hs_obs = 0; done_obs = 0; last_obs = 0;
    finished = 1'b0;
    for (int s = 0; s < NSEC; s++) hs_e[s] = -100;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 3000; g++) begin
      now = edge_cnt;
      exp_v    = (cur < NSEC) && (now >= p_e[cur]);
      exp_busy = (cur < NSEC);
      exp_done = (cur == NSEC) && (now == hs_e[NSEC-1]);
      n_tests++;
      if (sec_valid !== exp_v) begin
        n_fail++;
        $display("FAIL sec_valid edge=%0d got %0b exp %0b", now - e0, sec_valid, exp_v);
      end
      n_tests++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy edge=%0d got %0b exp %0b", now - e0, busy, exp_busy);
      end
      n_tests++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL done edge=%0d got %0b exp %0b", now - e0, done, exp_done);
      end
      if (done === 1'b1) done_obs++;
      if (!exp_busy) begin
        n_tests++;
        if (rom_addr !== AW'(BASE)) begin
          n_fail++;
          $display("FAIL idle_rom_addr got %0d exp %0d", rom_addr, BASE);
        end
      end
      if (exp_v) begin
        exp_bundle = {exp_q[0], exp_q[1], exp_q[2], exp_q[3], exp_q[4]};
        n_tests++;
        if (sec_idx !== 3'(cur)) begin
          n_fail++;
          $display("FAIL sec_idx got %0d exp %0d", sec_idx, cur);
        end
        n_tests++;
        if ({sec_b0, sec_b1, sec_b2, sec_a1, sec_a2} !== exp_bundle) begin
          n_fail++;
          $display("FAIL bundle sec=%0d got %h exp %h", cur,
                   {sec_b0, sec_b1, sec_b2, sec_a1, sec_a2}, exp_bundle);
        end
        if (mode == 0 && cur == 0) begin
          n_tests++;
          if ({sec_b0, sec_b1, sec_b2, sec_a1, sec_a2} !== 80'h0E29_1DB3_0F93_B7BC_16FD) begin
            n_fail++;
            $display("FAIL sec0_const got %h exp 0e291db30f93b7bc16fd",
                     {sec_b0, sec_b1, sec_b2, sec_a1, sec_a2});
          end
        end
        if (mode == 0 && cur == 4) begin
          n_tests++;
          if ({sec_a1, sec_a2} !== 32'h029F_3B16) begin
            n_fail++;
            $display("FAIL sec4_const got %h exp 029f3b16", {sec_a1, sec_a2});
          end
        end
      end
      if (cur == NSEC && now >= hs_e[NSEC-1] + 3) begin
        finished = 1'b1;
        break;
      end
      // Reset while section 1 is presented.
      if (stop_kind == 2 && cur == 1 && exp_v) begin
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sec_valid, busy, done, rom_addr, sec_idx} !== {3'b000, AW'(BASE), 3'd0}) begin
          n_fail++;
          $display("FAIL mid_reset_ctrl got %b", {sec_valid, busy, done, rom_addr, sec_idx});
        end
        n_tests++;
        if ({sec_b0, sec_b1, sec_b2, sec_a1, sec_a2} !== '0) begin
          n_fail++;
          $display("FAIL mid_reset_coef got %h exp 0", {sec_b0, sec_b1, sec_b2, sec_a1, sec_a2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      // Abort two edges into the fetch of section 3.
      if (stop_kind == 1 && cur == 3 && now == hs_e[2] + 2) begin
        abort = 1'b1;
        sec_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 10; i++) begin
          n_tests++;
          if ({sec_valid, busy, done, rom_addr} !== {3'b000, AW'(BASE)}) begin
            n_fail++;
            $display("FAIL abort_idle cyc=%0d got %b exp %b", i,
                     {sec_valid, busy, done, rom_addr}, {3'b000, AW'(BASE)});
          end
          @(negedge clk);
        end
        return;
      end
      // Ready for the next edge.
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ($urandom_range(0, 2) != 0);
        2: begin
          rdy = 1'b1;
          if (cur == 2 && exp_v && stall < 20) begin
            rdy = 1'b0;
            stall++;
            n_tests++;
            if ({sec_idx, sec_a1, sec_a2} !== {3'd2, 32'hE373_27A1}) begin
              n_fail++;
              $display("FAIL stall_hold got idx=%0d a=%h exp idx=2 a=e37327a1",
                       sec_idx, {sec_a1, sec_a2});
            end
          end
        end
        default: rdy = (now >= e0 + 10);
      endcase
      start = 1'b0;
      if (cur < NSEC && mode == 1) start = ($urandom_range(0, 3) == 0);
      if (cur == NSEC - 1 && exp_v && rdy) start = 1'b1;  // must be ignored
      if (sec_valid === 1'b1 && rdy) begin
        hs_obs++;
        last_obs = now + 1;
      end
      if (exp_v && rdy) begin
        hs_e[cur] = now + 1;
        if (cur + 1 < NSEC) begin
`ifdef OPTI_COEFF_PREFETCH_EN
          c = f_e[cur] + 1;
          if (cur >= 1 && hs_e[cur-1] > c) c = hs_e[cur-1];
          f_e[cur+1] = c + 4;
          p_e[cur+1] = (f_e[cur+1] > now + 1) ? f_e[cur+1] : now + 1;
`else
          f_e[cur+1] = now + 6;
          p_e[cur+1] = now + 6;
`endif
        end
        repeat (5) dummy = exp_q.pop_front();
        cur++;
      end
      sec_ready = rdy;
      @(negedge clk);
    end
    start = 1'b0;
    sec_ready = 1'b0;
    n_tests++;
    if (!finished) begin
      n_fail++;
      $display("FAIL timeout handshakes=%0d exp %0d", cur, NSEC);
    end
    n_tests++;
    if (hs_obs != NSEC) begin
      n_fail++;
      $display("FAIL handshake_count got %0d exp %0d", hs_obs, NSEC);
    end
    n_tests++;
    if (done_obs != 1) begin
      n_fail++;
      $display("FAIL done_pulses got %0d exp 1", done_obs);
    end
    if (mode == 0) begin
      n_tests++;
      if (last_obs - e0 != EXP_RUN) begin
        n_fail++;
        $display("FAIL run_length got %0d exp %0d", last_obs - e0, EXP_RUN);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_tests++;
      if ({sec_valid, busy, done, rom_addr, sec_idx} !== {3'b000, AW'(BASE), 3'd0}) begin
        n_fail++;
        $display("FAIL reset_ctrl cyc=%0d got %b", i, {sec_valid, busy, done, rom_addr, sec_idx});
      end
      n_tests++;
      if ({sec_b0, sec_b1, sec_b2, sec_a1, sec_a2} !== '0) begin
        n_fail++;
        $display("FAIL reset_coef cyc=%0d got %h exp 0", i, {sec_b0, sec_b1, sec_b2, sec_a1, sec_a2});
      end
    end
  endtask

  task automatic test_basic();
    run_stream(0, 0);
  endtask

  task automatic test_stall();
    run_stream(2, 0);
  endtask

  task automatic test_abort();
    run_stream(0, 1);
  endtask

  task automatic test_abort_start_idle();
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ({sec_valid, busy, done} !== 3'b000) begin
        n_fail++;
        $display("FAIL abort_start cyc=%0d got %b exp 000", i, {sec_valid, busy, done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    run_stream(0, 2);
    run_stream(0, 0);
  endtask

  task automatic test_burst();
    run_stream(3, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) run_stream(1, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = CW'($urandom);
    rom[0] = 16'h0E29; rom[1] = 16'h1DB3; rom[2] = 16'h0F93; rom[3] = 16'hB7BC; rom[4] = 16'h16FD;
    rom[13] = 16'hE373; rom[14] = 16'h27A1;
    rom[23] = 16'h029F; rom[24] = 16'h3B16;
    test_reset();
    test_basic();
    test_stall();
    test_abort();
    test_abort_start_idle();
    test_reset_mid();
    test_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
